// File: rtl/gemm_tile_scheduler_if.sv
// ----------------------------------------------------------------------------
// gemm_tile_scheduler_if
//   Command bus from the GEMM tile scheduler to the operand loader / matrix
//   multiplier. One command is offered at a time with a valid/ready handshake.
//
//   Signals:
//     valid   scheduler -> loader  command valid
//     ready   loader -> scheduler  loader accepts the command
//     t_idx   scheduler -> loader  tensor tile index
//     w_idx   scheduler -> loader  weight tile index
//     k_idx   scheduler -> loader  K-chunk index
//     last_k  scheduler -> loader  last K-chunk of the current output tile
//
//   Modports: master (scheduler side), slave (loader side).
// ----------------------------------------------------------------------------
interface gemm_tile_scheduler_if #(
  parameter int CNT_W = 16
) ();

  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] t_idx;
  logic [CNT_W-1:0] w_idx;
  logic [CNT_W-1:0] k_idx;
  logic             last_k;

  modport master (
    output valid,
    output t_idx,
    output w_idx,
    output k_idx,
    output last_k,
    input  ready
  );

  modport slave (
    input  valid,
    input  t_idx,
    input  w_idx,
    input  k_idx,
    input  last_k,
    output ready
  );

endinterface

// File: rtl/gemm_tile_scheduler.sv
// ----------------------------------------------------------------------------
// gemm_tile_scheduler
//   Sequences the img2col GEMM datapath. Walks weight tiles (outer), tensor
//   tiles (middle) and K-chunks (inner), issuing one multiply command per
//   chunk. Only one command is outstanding at a time; after the last K-chunk
//   of an output tile the scheduler waits for the accumulator to drain before
//   moving to the next tile. Generates tensor_done / weight_done markers and
//   a conv_done pulse at layer completion. A drain that never finishes raises
//   the sticky err flag after DRAIN_TIMEOUT cycles.
//
//   Parameters:
//     CNT_W          width of every tile/chunk count and index
//     DRAIN_TIMEOUT  cycles allowed in WAIT_DRAIN before err is raised
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     start, abort        layer start / abort pulses
//     cfg_k_nums          K-chunks per output tile (>=1)
//     cfg_t_nums          tensor tiles (>=1)
//     cfg_w_nums          weight tiles (>=1)
//     issue               command bus (gemm_tile_scheduler_if.master)
//     mul_done            product of the outstanding command delivered
//     drain_done          accumulator finished shifting out an output tile
//     tensor_done         pulse: last chunk of the last tensor tile accepted
//     weight_done         pulse: final command of the layer accepted
//     busy                scheduler not idle
//     conv_done           pulse: layer finished
//     err                 sticky: drain timeout or zero-sized configuration
//
//   Optional feature (macro GEMM_SCHED_PERF_EN):
//     perf_stall_cycles   32-bit saturating count of cycles with a command
//                         offered but not accepted, plus cycles spent in
//                         WAIT_DRAIN. Cleared on start.
// ----------------------------------------------------------------------------
module gemm_tile_scheduler #(
  parameter int CNT_W         = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CNT_W-1:0]          cfg_k_nums,
  input  logic [CNT_W-1:0]          cfg_t_nums,
  input  logic [CNT_W-1:0]          cfg_w_nums,
  gemm_tile_scheduler_if.master     issue,
  input  logic                      mul_done,
  input  logic                      drain_done,
  output logic                      tensor_done,
  output logic                      weight_done,
  output logic                      busy,
  output logic                      conv_done,
  output logic                      err
`ifdef GEMM_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles
`endif
);

  localparam int               DCW        = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);
  localparam logic [DCW-1:0]   DRAIN_ZERO = {DCW{1'b0}};
  localparam logic [DCW-1:0]   DRAIN_ONE  = DCW'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_MUL   = 3'd2,
    ST_WAIT_DRAIN = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  state_t           state, state_next;

  logic [CNT_W-1:0] k_cnt, k_nxt;
  logic [CNT_W-1:0] t_cnt, t_nxt;
  logic [CNT_W-1:0] w_cnt, w_nxt;
  logic             last_k, last_k_nxt;
  logic [CNT_W-1:0] cfg_k, cfg_k_nxt;
  logic [CNT_W-1:0] cfg_t, cfg_t_nxt;
  logic [CNT_W-1:0] cfg_w, cfg_w_nxt;
  logic [DCW-1:0]   drain_cnt, drain_nxt;
  logic             err_nxt;
  logic             tensor_done_nxt;
  logic             weight_done_nxt;
  logic             valid_q;
  logic             t_last;
  logic             w_last;

  assign t_last = (t_cnt == (cfg_t - CNT_ONE));
  assign w_last = (w_cnt == (cfg_w - CNT_ONE));

  // Command bus driven straight from registers so it is stable under backpressure.
  assign issue.valid  = valid_q;
  assign issue.t_idx  = t_cnt;
  assign issue.w_idx  = w_cnt;
  assign issue.k_idx  = k_cnt;
  assign issue.last_k = last_k;

  // Next-state and next-counter logic for the scheduling FSM.
  always_comb begin
    state_next      = state;
    k_nxt           = k_cnt;
    t_nxt           = t_cnt;
    w_nxt           = w_cnt;
    last_k_nxt      = last_k;
    cfg_k_nxt       = cfg_k;
    cfg_t_nxt       = cfg_t;
    cfg_w_nxt       = cfg_w;
    drain_nxt       = drain_cnt;
    err_nxt         = err;
    tensor_done_nxt = 1'b0;
    weight_done_nxt = 1'b0;

    if (abort) begin
      // Abort wins over everything but reset; err is deliberately kept.
      state_next = ST_IDLE;
      k_nxt      = CNT_ZERO;
      t_nxt      = CNT_ZERO;
      w_nxt      = CNT_ZERO;
      last_k_nxt = 1'b0;
      drain_nxt  = DRAIN_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if ((cfg_k_nums == CNT_ZERO) || (cfg_t_nums == CNT_ZERO) ||
                (cfg_w_nums == CNT_ZERO)) begin
              err_nxt = 1'b1;
            end else begin
              cfg_k_nxt  = cfg_k_nums;
              cfg_t_nxt  = cfg_t_nums;
              cfg_w_nxt  = cfg_w_nums;
              k_nxt      = CNT_ZERO;
              t_nxt      = CNT_ZERO;
              w_nxt      = CNT_ZERO;
              last_k_nxt = (cfg_k_nums == CNT_ONE);
              drain_nxt  = DRAIN_ZERO;
              err_nxt    = 1'b0;
              state_next = ST_ISSUE;
            end
          end else begin
            state_next = ST_IDLE;
          end
        end

        ST_ISSUE: begin
          // valid_q is always high in this state, so ready alone completes the handshake.
          if (issue.ready) begin
            state_next      = ST_WAIT_MUL;
            tensor_done_nxt = last_k && t_last;
            weight_done_nxt = last_k && t_last && w_last;
          end else begin
            state_next = ST_ISSUE;
          end
        end

        ST_WAIT_MUL: begin
          if (mul_done) begin
            if (!last_k) begin
              k_nxt      = k_cnt + CNT_ONE;
              last_k_nxt = ((k_cnt + CNT_ONE) == (cfg_k - CNT_ONE));
              state_next = ST_ISSUE;
            end else begin
              k_nxt      = CNT_ZERO;
              last_k_nxt = (cfg_k == CNT_ONE);
              drain_nxt  = DRAIN_ZERO;
              state_next = ST_WAIT_DRAIN;
            end
          end else begin
            state_next = ST_WAIT_MUL;
          end
        end

        ST_WAIT_DRAIN: begin
          if (drain_done) begin
            drain_nxt = DRAIN_ZERO;
            if (t_last && w_last) begin
              state_next = ST_DONE;
            end else begin
              if (t_last) begin
                t_nxt = CNT_ZERO;
                w_nxt = w_cnt + CNT_ONE;
              end else begin
                t_nxt = t_cnt + CNT_ONE;
              end
              state_next = ST_ISSUE;
            end
          end else if (drain_cnt == DRAIN_LAST) begin
            // DRAIN_TIMEOUT cycles spent here without drain_done.
            err_nxt    = 1'b1;
            state_next = ST_IDLE;
            k_nxt      = CNT_ZERO;
            t_nxt      = CNT_ZERO;
            w_nxt      = CNT_ZERO;
            last_k_nxt = 1'b0;
            drain_nxt  = DRAIN_ZERO;
          end else begin
            drain_nxt = drain_cnt + DRAIN_ONE;
          end
        end

        ST_DONE: begin
          state_next = ST_IDLE;
          k_nxt      = CNT_ZERO;
          t_nxt      = CNT_ZERO;
          w_nxt      = CNT_ZERO;
          last_k_nxt = 1'b0;
          drain_nxt  = DRAIN_ZERO;
        end

        default: begin
          state_next = ST_IDLE;
          k_nxt      = CNT_ZERO;
          t_nxt      = CNT_ZERO;
          w_nxt      = CNT_ZERO;
          last_k_nxt = 1'b0;
          drain_nxt  = DRAIN_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered outputs; outputs are decoded from state_next
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      k_cnt       <= CNT_ZERO;
      t_cnt       <= CNT_ZERO;
      w_cnt       <= CNT_ZERO;
      last_k      <= 1'b0;
      cfg_k       <= CNT_ZERO;
      cfg_t       <= CNT_ZERO;
      cfg_w       <= CNT_ZERO;
      drain_cnt   <= DRAIN_ZERO;
      err         <= 1'b0;
      tensor_done <= 1'b0;
      weight_done <= 1'b0;
      valid_q     <= 1'b0;
      busy        <= 1'b0;
      conv_done   <= 1'b0;
    end else begin
      state       <= state_next;
      k_cnt       <= k_nxt;
      t_cnt       <= t_nxt;
      w_cnt       <= w_nxt;
      last_k      <= last_k_nxt;
      cfg_k       <= cfg_k_nxt;
      cfg_t       <= cfg_t_nxt;
      cfg_w       <= cfg_w_nxt;
      drain_cnt   <= drain_nxt;
      err         <= err_nxt;
      tensor_done <= tensor_done_nxt;
      weight_done <= weight_done_nxt;
      valid_q     <= (state_next == ST_ISSUE);
      busy        <= (state_next != ST_IDLE);
      conv_done   <= (state_next == ST_DONE);
    end
  end

`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] perf_cnt, perf_nxt;

  // Stall accounting: backpressured command cycles plus drain-wait cycles.
  always_comb begin
    perf_nxt = perf_cnt;
    if ((state == ST_IDLE) && start && !abort) begin
      perf_nxt = 32'd0;
    end else if (((valid_q && !issue.ready) || (state == ST_WAIT_DRAIN)) &&
                 (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_nxt = perf_cnt + 32'd1;
    end else begin
      perf_nxt = perf_cnt;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= 32'd0;
    end else begin
      perf_cnt <= perf_nxt;
    end
  end

  assign perf_stall_cycles = perf_cnt;
`else
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// ----------------------------------------------------------------------------
// tb_gemm_tile_scheduler
//   Directed bench for gemm_tile_scheduler. The main instance runs layers
//   with a small loader/accumulator responder; a second instance with
//   DRAIN_TIMEOUT=8 exercises the drain timeout.
// ----------------------------------------------------------------------------
module tb_gemm_tile_scheduler;

  localparam int CNT_W     = 16;
  localparam int DRAIN_DLY = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, abort, mul_done, drain_done;
  logic [CNT_W-1:0] cfg_k, cfg_t, cfg_w;
  logic             tensor_done, weight_done, busy, conv_done, err;

  logic             start2, abort2, mul_done2, drain_done2;
  logic [CNT_W-1:0] cfg2;
  logic             tensor_done2, weight_done2, busy2, conv_done2, err2;

`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] perf, perf2;
`endif

  gemm_tile_scheduler_if #(.CNT_W(CNT_W)) sif ();
  gemm_tile_scheduler_if #(.CNT_W(CNT_W)) tif ();

  gemm_tile_scheduler #(.CNT_W(CNT_W), .DRAIN_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_k_nums(cfg_k), .cfg_t_nums(cfg_t), .cfg_w_nums(cfg_w),
    .issue(sif.master), .mul_done(mul_done), .drain_done(drain_done),
    .tensor_done(tensor_done), .weight_done(weight_done), .busy(busy),
    .conv_done(conv_done), .err(err)
`ifdef GEMM_SCHED_PERF_EN
    , .perf_stall_cycles(perf)
`endif
  );

  gemm_tile_scheduler #(.CNT_W(CNT_W), .DRAIN_TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .cfg_k_nums(cfg2), .cfg_t_nums(cfg2), .cfg_w_nums(cfg2),
    .issue(tif.master), .mul_done(mul_done2), .drain_done(drain_done2),
    .tensor_done(tensor_done2), .weight_done(weight_done2), .busy(busy2),
    .conv_done(conv_done2), .err(err2)
`ifdef GEMM_SCHED_PERF_EN
    , .perf_stall_cycles(perf2)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt = 0, td_cnt = 0, wd_cnt = 0, cd_cnt = 0;
  int td2_cnt = 0, wd2_cnt = 0, cd2_cnt = 0;

  // Pulse / handshake counters sampled on the falling edge.
  always @(negedge clk) begin
    if (sif.valid && sif.ready) hs_cnt++;
    if (tensor_done)  td_cnt++;
    if (weight_done)  wd_cnt++;
    if (conv_done)    cd_cnt++;
    if (tensor_done2) td2_cnt++;
    if (weight_done2) wd2_cnt++;
    if (conv_done2)   cd2_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs one layer on the main instance, checking every command against the
  // w/t/k loop nest. stall_cmd: command number held off 5 cycles (0 = none).
  // abort_cmd: command after whose handshake abort is pulsed (0 = none).
  // dup_start: pulse start again while busy.
  task automatic run_layer(input int k, input int t, input int w,
                           input int stall_cmd, input int abort_cmd, input bit dup_start);
    int hs0 = hs_cnt, td0 = td_cnt, wd0 = wd_cnt, cd0 = cd_cnt;
    int n = 0;
    int waitc;
    bit final_cmd;
    cfg_k = CNT_W'(k); cfg_t = CNT_W'(t); cfg_w = CNT_W'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Changing the configuration now must not affect the running layer.
    cfg_k = 16'd5; cfg_t = 16'd5; cfg_w = 16'd5;
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_err_clr", err, 1'b0);
    for (int wi = 0; wi < w; wi++) begin
      for (int ti = 0; ti < t; ti++) begin
        for (int ki = 0; ki < k; ki++) begin
          n++;
          final_cmd = (wi == w - 1) && (ti == t - 1) && (ki == k - 1);
          waitc = 0;
          while (!sif.valid && waitc < 50) begin
            tick();
            waitc++;
          end
          check_eq("valid_seen", sif.valid, 1'b1);
          if (!sif.valid) return;
          check_eq("t_idx", sif.t_idx, 64'(ti));
          check_eq("w_idx", sif.w_idx, 64'(wi));
          check_eq("k_idx", sif.k_idx, 64'(ki));
          check_eq("last_k", sif.last_k, 64'(ki == k - 1));
          if (n == stall_cmd) begin
            sif.ready = 1'b0;
            repeat (5) begin
              tick();
              check_eq("stall_valid", sif.valid, 1'b1);
              check_eq("stall_idx", {sif.w_idx, sif.t_idx, sif.k_idx},
                       {CNT_W'(wi), CNT_W'(ti), CNT_W'(ki)});
              check_eq("stall_last_k", sif.last_k, 64'(ki == k - 1));
            end
            sif.ready = 1'b1;
          end
          tick();  // handshake edge
          check_eq("valid_drop", sif.valid, 1'b0);
          check_eq("tensor_done", tensor_done, 64'((ki == k - 1) && (ti == t - 1)));
          check_eq("weight_done", weight_done, 64'(final_cmd));
          if (n == abort_cmd) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_eq("abort_busy", busy, 1'b0);
            check_eq("abort_valid", sif.valid, 1'b0);
            mul_done = 1'b1;
            tick();
            mul_done = 1'b0;
            repeat (3) tick();
            check_eq("late_mul_busy", busy, 1'b0);
            check_eq("late_mul_valid", sif.valid, 1'b0);
            check_eq("abort_no_conv", cd_cnt - cd0, 0);
            return;
          end
          if (dup_start && n == 1) begin
            cfg_k = 16'd1; cfg_t = 16'd1; cfg_w = 16'd1;
            start = 1'b1;
            tick();
            start = 1'b0;
          end else begin
            tick();
          end
          mul_done = 1'b1;
          tick();
          mul_done = 1'b0;
          if (ki == k - 1) begin
            repeat (DRAIN_DLY - 1) tick();
            check_eq("drain_busy", busy, 1'b1);
            check_eq("drain_no_conv", conv_done, 1'b0);
            drain_done = 1'b1;
            tick();
            drain_done = 1'b0;
          end
          if (!final_cmd) check_eq("next_valid", sif.valid, 1'b1);
        end
      end
    end
    check_eq("conv_done", conv_done, 1'b1);
    check_eq("busy_in_done", busy, 1'b1);
    tick();
    check_eq("conv_done_fall", conv_done, 1'b0);
    check_eq("busy_fall", busy, 1'b0);
    check_eq("hs_count", hs_cnt - hs0, k * t * w);
    check_eq("td_count", td_cnt - td0, w);
    check_eq("wd_count", wd_cnt - wd0, 1);
    check_eq("cd_count", cd_cnt - cd0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mul_done = 1'b0; drain_done = 1'b0;
    cfg_k = 16'd1; cfg_t = 16'd1; cfg_w = 16'd1;
    start2 = 1'b0; abort2 = 1'b0; mul_done2 = 1'b0; drain_done2 = 1'b0; cfg2 = 16'd1;
    sif.ready = 1'b1;
    tif.ready = 1'b1;
    repeat (3) tick();

    // Reset state.
    check_eq("rst_valid", sif.valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_pulses", {tensor_done, weight_done, conv_done}, 3'b000);
    check_eq("rst_idx", {sif.t_idx, sif.w_idx, sif.k_idx, sif.last_k}, 49'd0);
    check_eq("rst_busy2", busy2, 1'b0);
`ifdef GEMM_SCHED_PERF_EN
    check_eq("rst_perf", perf, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // k=3, t=2, w=1.
    run_layer(3, 2, 1, 0, 0, 1'b0);
    // k=1, t=3, w=2: every command last_k, tensor_done twice.
    run_layer(1, 3, 2, 0, 0, 1'b0);
    // Backpressure on the 2nd command.
    run_layer(2, 1, 1, 2, 0, 1'b0);
`ifdef GEMM_SCHED_PERF_EN
    check_eq("perf_stall", perf, 32'd5 + 32'(DRAIN_DLY));
`endif
    // Abort in WAIT_MUL of the 3rd command, then a fresh layer from (0,0,0)
    // with a start pulse while busy.
    run_layer(2, 2, 1, 0, 3, 1'b0);
    run_layer(2, 2, 1, 0, 0, 1'b1);

    // Zero-sized configuration.
    cfg_k = 16'd2; cfg_t = 16'd0; cfg_w = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("zero_err", err, 1'b1);
    check_eq("zero_busy", busy, 1'b0);
    repeat (4) tick();
    check_eq("zero_valid", sif.valid, 1'b0);
    check_eq("zero_busy_hold", busy, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_keeps_err", err, 1'b1);
    run_layer(1, 1, 1, 0, 0, 1'b0);

    // Reset mid-operation.
    cfg_k = 16'd2; cfg_t = 16'd2; cfg_w = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_valid", sif.valid, 1'b0);
    check_eq("rst_mid_idx", {sif.t_idx, sif.w_idx, sif.k_idx}, 48'd0);

    // Drain timeout on the DRAIN_TIMEOUT=8 instance.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_eq("to_valid", tif.valid, 1'b1);
    check_eq("to_idx", {tif.t_idx, tif.w_idx, tif.k_idx, tif.last_k}, {48'd0, 1'b1});
    tick();  // handshake
    tick();
    mul_done2 = 1'b1;
    tick();  // enters WAIT_DRAIN
    mul_done2 = 1'b0;
    repeat (7) tick();
    check_eq("to_busy_7", busy2, 1'b1);
    check_eq("to_err_7", err2, 1'b0);
    tick();
    check_eq("to_busy_8", busy2, 1'b0);
    check_eq("to_err_8", err2, 1'b1);
    repeat (2) tick();
    check_eq("to_no_conv", cd2_cnt, 0);
    check_eq("to_td_wd", {td2_cnt[7:0], wd2_cnt[7:0]}, 16'h0101);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    check_eq("to_abort_err", err2, 1'b1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_eq("to_restart_err", err2, 1'b0);
    check_eq("to_restart_busy", busy2, 1'b1);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    check_eq("to_final_busy", busy2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
